// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: instruction decode with valid/ready handshake and RAW/WAW scoreboard (DECODE_FORWARD_EN relaxes busy to cnt > 1)
module decode_hazard_stage #(
  parameter int OPCODE_W   = 7,
  parameter int PRIM_W     = 5,
  parameter int SEC_W      = 16,
  parameter int WB_LATENCY = 3
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                isBranch_i,
  input  logic                instructionFormat_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [PRIM_W-1:0]   primOperand_i,
  input  logic [SEC_W-1:0]    secOperand_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [PRIM_W-1:0]   primOperand_o,
  output logic [SEC_W-1:0]    secOperand_o,
  output logic [1:0]          functionType_o,
  output logic                pRead_o,
  output logic                pWrite_o,
  output logic                sRead_o,
  output logic                illegal_o,
  output logic                stall_o
);
  localparam int NUM_REGS = 2 ** PRIM_W;
  localparam int CNT_W = $clog2(WB_LATENCY + 1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic is_nop, is_arith, is_ld, is_st, is_br, is_rf, legal;
  logic d_pread, d_pwrite, d_sread;
  logic [1:0] d_type;
  logic busy_p, busy_s, hazard, advance, accept;
  logic [PRIM_W-1:0] sec_reg;

  assign is_nop   = opcode_i == '0;
  assign is_arith = opcode_i >= OPCODE_W'(1) && opcode_i <= OPCODE_W'(3);
  assign is_ld    = opcode_i == OPCODE_W'(4) || opcode_i == OPCODE_W'(5);
  assign is_st    = opcode_i == OPCODE_W'(6);
  assign is_br    = opcode_i >= OPCODE_W'(7) && opcode_i <= OPCODE_W'(10);
  assign is_rf    = opcode_i >= OPCODE_W'(11) && opcode_i <= OPCODE_W'(14);
  assign legal    = isBranch_i ? is_br : (is_nop | is_arith | is_ld | is_st | is_rf);

  // decode flags and function type; illegal opcodes collapse to a flagged nop
  always_comb begin
    d_pread  = legal & (is_arith | is_st | is_br);
    d_pwrite = legal & (is_arith | is_ld);
    d_sread  = legal & ~instructionFormat_i & (is_arith | is_ld | is_st | is_br);
    d_type   = ~legal ? 2'd0 : is_br ? 2'd2 : is_rf ? 2'd3 : (is_ld | is_st) ? 2'd1 : 2'd0;
  end

  assign sec_reg = secOperand_i[PRIM_W-1:0];
`ifdef DECODE_FORWARD_EN
  assign busy_p = cnt[primOperand_i] > CNT_W'(1);
  assign busy_s = cnt[sec_reg] > CNT_W'(1);
`else
  assign busy_p = cnt[primOperand_i] != '0;
  assign busy_s = cnt[sec_reg] != '0;
`endif

  assign hazard  = valid_i & ((d_pread & busy_p) | (d_sread & busy_s) | (d_pwrite & busy_p));
  assign stall_o = hazard & valid_i;
  assign advance = ~valid_o | ready_i;
  assign ready_o = advance & ~hazard & ~reset_i;
  assign accept  = valid_i & ready_o;

  // output register: load on accept, drop valid when advancing without a new instruction
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_o        <= 1'b0;
      opcode_o       <= '0;
      primOperand_o  <= '0;
      secOperand_o   <= '0;
      functionType_o <= '0;
      pRead_o        <= 1'b0;
      pWrite_o       <= 1'b0;
      sRead_o        <= 1'b0;
      illegal_o      <= 1'b0;
    end else if (accept) begin
      valid_o        <= 1'b1;
      opcode_o       <= opcode_i;
      primOperand_o  <= primOperand_i;
      secOperand_o   <= secOperand_i;
      functionType_o <= d_type;
      pRead_o        <= d_pread;
      pWrite_o       <= d_pwrite;
      sRead_o        <= d_sread;
      illegal_o      <= ~legal;
    end else if (advance) begin
      valid_o <= 1'b0;
    end
  end

  // scoreboard: a new writer reloads its counter, others count down only while the pipe advances
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset_i)
        cnt[i] <= '0;
      else if (accept && d_pwrite && primOperand_i == PRIM_W'(i))
        cnt[i] <= CNT_W'(WB_LATENCY);
      else if (advance && cnt[i] != '0)
        cnt[i] <= cnt[i] - 1'b1;
    end
  end
endmodule
